// File: rtl/blit_rectgen.sv
// Rectangle blit address generator: walks a width x height rectangle in row-major
// order and emits paired destination/source coordinates with a clip-window write enable.
module blit_rectgen #(
  parameter int CW      = 16,
  parameter bit CLIP_EN = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          flip_x,
  input  logic          flip_y,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] height,
  input  logic [CW-1:0] dst_x,
  input  logic [CW-1:0] dst_y,
  input  logic [CW-1:0] src_x,
  input  logic [CW-1:0] src_y,
  input  logic [CW-1:0] clip_x0,
  input  logic [CW-1:0] clip_y0,
  input  logic [CW-1:0] clip_x1,
  input  logic [CW-1:0] clip_y1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_dest_x,
  output logic [CW-1:0] out_dest_y,
  output logic [CW-1:0] out_src_x,
  output logic [CW-1:0] out_src_y,
  output logic          out_write_enable,
  output logic          busy,
  output logic          done,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_next;

  logic          fx_q, fy_q;
  logic [CW-1:0] w_q, h_q, dx_q, dy_q, sx_q, sy_q;
  logic [CW-1:0] cx0_q, cy0_q, cx1_q, cy1_q;
  logic [CW-1:0] x, y;
  logic          gen_done;   // final beat has already been loaded into the output register

  logic          accept, xfer, load, last_xfer, abort_run;
  logic [CW-1:0] cur_dx, cur_dy, cur_sx, cur_sy;
  logic          cur_we;

  // Handshake: a beat moves when out_valid && out_ready; while out_valid is high and
  // out_ready is low every out_* signal holds. The register refills when empty or draining.
  assign accept    = (state == IDLE) && start;
  assign abort_run = (state == RUN) && abort;
  assign xfer      = out_valid && out_ready;
  assign load      = (state == RUN) && !abort && !gen_done && (!out_valid || out_ready);
  assign last_xfer = (state == RUN) && xfer && gen_done;

  assign cur_dx = fx_q ? (dx_q - x) : (dx_q + x);
  assign cur_sx = fx_q ? (sx_q - x) : (sx_q + x);
  assign cur_dy = fy_q ? (dy_q - y) : (dy_q + y);
  assign cur_sy = fy_q ? (sy_q - y) : (sy_q + y);

  generate
    if (CLIP_EN) begin : g_clip
      assign cur_we = (cur_dx >= cx0_q) && (cur_dx < cx1_q) &&
                      (cur_dy >= cy0_q) && (cur_dy < cy1_q);
    end else begin : g_noclip
      assign cur_we = 1'b1;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ((width == '0) || (height == '0)) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort)          state_next = IDLE;
        else if (last_xfer) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      {fx_q, fy_q}                   <= '0;
      {w_q, h_q, dx_q, dy_q}         <= '0;
      {sx_q, sy_q}                   <= '0;
      {cx0_q, cy0_q, cx1_q, cy1_q}   <= '0;
      x                              <= '0;
      y                              <= '0;
      gen_done                       <= 1'b0;
      out_valid                      <= 1'b0;
      out_write_enable               <= 1'b0;
      out_dest_x                     <= '0;
      out_dest_y                     <= '0;
      out_src_x                      <= '0;
      out_src_y                      <= '0;
    end else begin
      if (accept) begin
        fx_q     <= flip_x;
        fy_q     <= flip_y;
        w_q      <= width;
        h_q      <= height;
        dx_q     <= dst_x;
        dy_q     <= dst_y;
        sx_q     <= src_x;
        sy_q     <= src_y;
        cx0_q    <= clip_x0;
        cy0_q    <= clip_y0;
        cx1_q    <= clip_x1;
        cy1_q    <= clip_y1;
        x        <= '0;
        y        <= '0;
        gen_done <= 1'b0;
      end
      if (abort_run) begin
        out_valid        <= 1'b0;
        out_write_enable <= 1'b0;
      end else if (load) begin
        out_valid        <= 1'b1;
        out_write_enable <= cur_we;
        out_dest_x       <= cur_dx;
        out_dest_y       <= cur_dy;
        out_src_x        <= cur_sx;
        out_src_y        <= cur_sy;
        // x never exceeds width-1, so full-range widths cannot overflow the counter
        if (x == w_q - 1'b1) begin
          x <= '0;
          if (y == h_q - 1'b1) gen_done <= 1'b1;
          else                 y        <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else if (xfer) begin
        out_valid        <= 1'b0;
        out_write_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blit_rectgen.sv
// Directed bench for blit_rectgen: table of commands with hand-computed beat lists,
// plus hand-written abort, reset and zero-size sequences.
module tb_blit_rectgen;

  localparam int CW = 16;
  localparam int BW = 4 * CW + 1;

  typedef struct packed {
    logic [CW-1:0] dx, dy, sx, sy;
    logic          we;
  } beat_t;

  typedef struct {
    logic [CW-1:0] w, h, dx, dy, sx, sy, cx0, cy0, cx1, cy1;
    logic          fx, fy;
    int            ready_mode;
    int            first, n;
  } cmd_t;

  logic          clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic          flip_x = 1'b0, flip_y = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] width = '0, height = '0, dst_x = '0, dst_y = '0, src_x = '0, src_y = '0;
  logic [CW-1:0] clip_x0 = '0, clip_y0 = '0, clip_x1 = '0, clip_y1 = '0;
  logic          out_valid, out_write_enable, busy, done;
  logic [CW-1:0] out_dest_x, out_dest_y, out_src_x, out_src_y;
  logic [1:0]    fsm_state;

  cmd_t            cmds[5];
  beat_t           beats[22];
  logic [BW-1:0]   exp_q[$];
  int              n_cmp = 0, n_fail = 0;

  blit_rectgen #(.CW(CW), .CLIP_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .flip_x(flip_x), .flip_y(flip_y), .width(width), .height(height),
    .dst_x(dst_x), .dst_y(dst_y), .src_x(src_x), .src_y(src_y),
    .clip_x0(clip_x0), .clip_y0(clip_y0), .clip_x1(clip_x1), .clip_y1(clip_y1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dest_x(out_dest_x), .out_dest_y(out_dest_y),
    .out_src_x(out_src_x), .out_src_y(out_src_y),
    .out_write_enable(out_write_enable), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  function automatic logic [BW-1:0] beat_now();
    return {out_dest_x, out_dest_y, out_src_x, out_src_y, out_write_enable};
  endfunction

  task automatic check(input string name, input logic [BW:0] act, input logic [BW:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_cmd(input int i, input int w, input int h, input int dx, input int dy,
                         input int sx, input int sy, input bit fx, input bit fy,
                         input int cx0, input int cy0, input int cx1, input int cy1,
                         input int mode, input int first, input int n);
    cmds[i].w = w[CW-1:0];     cmds[i].h = h[CW-1:0];
    cmds[i].dx = dx[CW-1:0];   cmds[i].dy = dy[CW-1:0];
    cmds[i].sx = sx[CW-1:0];   cmds[i].sy = sy[CW-1:0];
    cmds[i].fx = fx;           cmds[i].fy = fy;
    cmds[i].cx0 = cx0[CW-1:0]; cmds[i].cy0 = cy0[CW-1:0];
    cmds[i].cx1 = cx1[CW-1:0]; cmds[i].cy1 = cy1[CW-1:0];
    cmds[i].ready_mode = mode; cmds[i].first = first; cmds[i].n = n;
  endtask

  task automatic add_beat(input int i, input int dx, input int dy, input int sx, input int sy,
                          input bit we);
    beats[i] = '{dx[CW-1:0], dy[CW-1:0], sx[CW-1:0], sy[CW-1:0], we};
  endtask

  // driver: apply command inputs and pulse start for one edge
  task automatic drive_cmd(input cmd_t c);
    width = c.w; height = c.h; dst_x = c.dx; dst_y = c.dy; src_x = c.sx; src_y = c.sy;
    flip_x = c.fx; flip_y = c.fy;
    clip_x0 = c.cx0; clip_y0 = c.cy0; clip_x1 = c.cx1; clip_y1 = c.cy1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    width = 16'd9; height = 16'd9; dst_x = 16'h1234; src_x = 16'h4321;
    flip_x = ~c.fx; clip_x1 = 16'd0;
  endtask

  task automatic run_cmd(input int i);
    cmd_t  c;
    logic [BW-1:0] held;
    logic  stalled;
    bit    finished;
    int    last_cyc;
    c = cmds[i];
    for (int j = c.first; j < c.first + c.n; j++) exp_q.push_back(beats[j]);
    out_ready = 1'b1;
    drive_cmd(c);
    check($sformatf("cmd%0d_busy_after_start", i), {65'd0, busy}, 66'd1);
    stalled = 1'b0; finished = 1'b0; last_cyc = -10; held = '0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      out_ready = (c.ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (stalled) check($sformatf("cmd%0d_hold", i), {out_valid, beat_now()}, {1'b1, held});
      if (done) begin
        check($sformatf("cmd%0d_done_after_last", i), (cyc - last_cyc), 66'd1);
        check($sformatf("cmd%0d_all_beats", i), exp_q.size(), 66'd0);
        check($sformatf("cmd%0d_done_no_valid", i), {65'd0, out_valid}, 66'd0);
        finished = 1'b1;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check($sformatf("cmd%0d_extra_beat", i), 66'd1, 66'd0);
          else check($sformatf("cmd%0d_beat", i), {1'b0, beat_now()}, {1'b0, exp_q.pop_front()});
          last_cyc = cyc;
        end
        stalled = out_valid && !out_ready;
        held    = beat_now();
        @(negedge clock);
      end
    end
    if (!finished) check($sformatf("cmd%0d_timeout", i), 66'd1, 66'd0);
    exp_q.delete();
    @(negedge clock);
    check($sformatf("cmd%0d_done_one_cycle", i), {64'd0, done, busy}, 66'd0);
  endtask

  initial begin
    // basic, flip, clip, wrap (dest_x 65535 sits outside x1=65535), backpressure
    add_cmd(0, 3, 2, 10, 20, 0, 0, 0, 0, 0, 0, 65535, 65535, 0, 0, 6);
    add_cmd(1, 2, 2, 5, 5, 100, 100, 1, 1, 0, 0, 65535, 65535, 0, 6, 4);
    add_cmd(2, 4, 1, 8, 0, 0, 0, 0, 0, 9, 0, 11, 1, 0, 10, 4);
    add_cmd(3, 2, 1, 65535, 7, 3, 3, 0, 0, 0, 0, 65535, 65535, 0, 14, 2);
    add_cmd(4, 3, 2, 10, 20, 0, 0, 0, 0, 0, 0, 65535, 65535, 1, 16, 6);
    add_beat(0, 10, 20, 0, 0, 1);  add_beat(1, 11, 20, 1, 0, 1);  add_beat(2, 12, 20, 2, 0, 1);
    add_beat(3, 10, 21, 0, 1, 1);  add_beat(4, 11, 21, 1, 1, 1);  add_beat(5, 12, 21, 2, 1, 1);
    add_beat(6, 5, 5, 100, 100, 1); add_beat(7, 4, 5, 99, 100, 1);
    add_beat(8, 5, 4, 100, 99, 1);  add_beat(9, 4, 4, 99, 99, 1);
    add_beat(10, 8, 0, 0, 0, 0);   add_beat(11, 9, 0, 1, 0, 1);
    add_beat(12, 10, 0, 2, 0, 1);  add_beat(13, 11, 0, 3, 0, 0);
    add_beat(14, 65535, 7, 3, 3, 0); add_beat(15, 0, 7, 4, 3, 1);
    for (int j = 0; j < 6; j++) beats[16 + j] = beats[j];

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_outputs", {out_valid, beat_now()}, 66'd0);
    check("reset_status", {63'd0, busy, done, out_valid}, 66'd0);

    for (int i = 0; i < 5; i++) run_cmd(i);

    // zero-size command: done on the first cycle, no beats
    cmds[0].w = 16'd0;
    drive_cmd(cmds[0]);
    check("zero_done", {63'd0, done, busy, out_valid}, 66'b110);
    @(negedge clock);
    check("zero_idle", {63'd0, done, busy, out_valid}, 66'd0);
    cmds[0].w = 16'd3;

    // abort after two beats have transferred
    out_ready = 1'b1;
    drive_cmd(cmds[0]);
    @(negedge clock);
    check("abort_beat0", {out_valid, beat_now()}, {1'b1, beats[0]});
    @(negedge clock);
    check("abort_beat1", {out_valid, beat_now()}, {1'b1, beats[1]});
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_stop", {63'd0, out_valid, busy, done}, 66'd0);
    @(negedge clock);
    check("abort_no_done", {64'd0, busy, done}, 66'd0);

    // reset in the middle of a command
    drive_cmd(cmds[0]);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_outputs", {out_valid, beat_now()}, 66'd0);
    check("midreset_status", {64'd0, busy, done}, 66'd0);
    @(negedge clock);
    check("midreset_no_done", {64'd0, busy, done}, 66'd0);

    // a fresh command still runs cleanly after the mid-command reset
    run_cmd(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/blit_rectgen.md
BLIT_RECTGEN -- requirements
Module: blit_rectgen

Interface
REQ-001 Parameter CW, default 16, coordinate and size width in bits.
REQ-002 Parameter CLIP_EN, default 1, enables the destination clip window (0 = clip logic removed).
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  command request, sampled only in IDLE.
REQ-006 abort  in  1  terminate the current command.
REQ-007 flip_x, flip_y  in  1 each  per-axis step direction (0 = increment, 1 = decrement).
REQ-008 width, height  in  CW each  rectangle size in pixels.
REQ-009 dst_x, dst_y, src_x, src_y  in  CW each  destination and source origins.
REQ-010 clip_x0, clip_y0, clip_x1, clip_y1  in  CW each  clip window: x0/y0 inclusive, x1/y1 exclusive, unsigned.
REQ-011 out_valid  out  1  output beat valid.
REQ-012 out_ready  in  1  downstream accepts beat.
REQ-013 out_dest_x, out_dest_y, out_src_x, out_src_y  out  CW each  beat coordinates.
REQ-014 out_write_enable  out  1  beat destination lies inside the clip window.
REQ-015 busy  out  1  command in progress.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 In IDLE with start=1, the block SHALL latch all command inputs at that edge (N) and clear the counters x=y=0.
- Next state: RUN, or DONE if width==0 or height==0.
- Command inputs SHALL be ignored at all other times.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 In RUN, the first beat (x=0, y=0) SHALL load into the output register at edge N+1, so out_valid=1 from then on.
REQ-021 A beat SHALL transfer on a cycle with out_valid && out_ready.
- The output register SHALL reload whenever it is empty or being transferred, giving one beat per cycle under continuous out_ready.
REQ-022 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-023 Beat order SHALL be row-major with x fastest.
- When x reaches width-1, x wraps to 0 and y increments.
- Exactly width*height beats SHALL be emitted.
REQ-024 out_dest_x SHALL equal dst_x+x when flip_x=0 and dst_x-x when flip_x=1; out_src_x SHALL follow the same rule from src_x.
- The y axis SHALL use the same rule with flip_y.
- All results SHALL be modulo 2^CW.
REQ-025 With CLIP_EN=1, out_write_enable SHALL be 1 iff clip_x0<=out_dest_x<clip_x1 and clip_y0<=out_dest_y<clip_y1.
- Clipped beats SHALL still be emitted so the source and destination streams stay aligned.
- With CLIP_EN=0, out_write_enable SHALL be 1 on every valid beat.
REQ-026 Transfer of the final beat SHALL move the FSM to DONE.
- If no new beat loads, out_valid SHALL be 0 on the next cycle.
REQ-027 DONE SHALL last exactly one cycle, assert done=1, and return to IDLE.
- start SHALL next be accepted one cycle after DONE.
REQ-028 A zero-size command SHALL produce no valid beats and SHALL pulse done at edge N+1.
REQ-029 abort=1 in RUN SHALL force IDLE at the next edge with out_valid=0 and busy=0, and SHALL NOT pulse done.
- abort SHALL have no effect in IDLE or DONE.
REQ-030 Counter and coordinate arithmetic SHALL be CW bits wide; widths up to 2^CW-1 SHALL complete without counter overflow.

Reset
REQ-031 reset=1 SHALL force IDLE and clear x, y, out_valid, out_write_enable, busy and done.
- out_dest_x, out_dest_y, out_src_x and out_src_y SHALL reset to 0.
REQ-032 Reset SHALL take priority over start and abort, including mid-command; no done pulse SHALL follow.

Verification
REQ-033 Basic: width=3, height=2, dst=(10,20), src=(0,0), flips=0, out_ready=1, clip=(0,0,65535,65535).
- Expect 6 beats with dest (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all write_enable=1.
- Expect the done pulse one cycle after the last beat.
REQ-034 Flip: flip_x=1, flip_y=1, width=2, height=2, dst=(5,5), src=(100,100).
- Expect dest (5,5),(4,5),(5,4),(4,4) and src (100,100),(99,100),(100,99),(99,99).
REQ-035 Backpressure: basic command with out_ready toggled 1,0,0,1,... .
- Expect out_* held constant while stalled, no beat lost or duplicated, 6 transfers total.
REQ-036 Clip: width=4, height=1, dst=(8,0), clip=(9,0,11,1).
- Expect write_enable sequence 0,1,1,0.
REQ-037 Boundaries:
- width=0 -> done at N+1 with no beats.
- abort after 2 beats -> out_valid=0 and busy=0 next cycle, no done.
- reset asserted mid-command -> all outputs 0.
REQ-038 Wrap: dst_x=65535, width=2 (CW=16) -> dest_x sequence 65535, 0.
